line_draw_arbiter: RTL and testbench

- Shares one line-drawing engine (go/done handshake; colour, x0, y0, x1, y1 operands) between NREQ independent requesters, e.g. the Avalon register slave and a hardware sprite/test-pattern source.
- Round-robin arbitration, latches the winner's operands, sequences a full four-phase go/done transaction, then returns a one-cycle ack to the winner.
- Sits between the requesters and the line drawer in the VGA peripheral path.

---
 rtl/line_draw_arbiter.sv | 139 +++++++++++++
 tb/tb_line_draw_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_draw_arbiter.sv
// Round-robin owner of one go/done line drawer; go rises 1 cycle after req, ack pulses 1 cycle after done falls.
// Losing requesters simply hold req until served; LDA_WATCHDOG_EN adds a timeout abort with a sticky error flag.
module line_draw_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] req_colour,
  input  logic [9*NREQ-1:0] req_x0,
  input  logic [9*NREQ-1:0] req_x1,
  input  logic [8*NREQ-1:0] req_y0,
  input  logic [8*NREQ-1:0] req_y1,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  input  logic              done,
  output logic              go,
  output logic [2:0]        colour,
  output logic [8:0]        x0,
  output logic [8:0]        x1,
  output logic [7:0]        y0,
  output logic [7:0]        y1
`ifdef LDA_WATCHDOG_EN
  ,
  output logic              error
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t          state;
  logic [PW-1:0]   last;
  logic [NREQ-1:0] eff;
  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   idx;

  // A requester whose ack is on the wire this cycle is still holding req; mask it out.
  always_comb begin
    eff   = req & ~ack;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = PW'((int'(last) + off) % NREQ);
      if (!found && eff[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

`ifdef LDA_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      go     <= 1'b0;
      ack    <= '0;
      grant  <= '0;
      busy   <= 1'b0;
      colour <= '0;
      x0     <= '0;
      x1     <= '0;
      y0     <= '0;
      y1     <= '0;
      last   <= PW'(NREQ - 1);
`ifdef LDA_WATCHDOG_EN
      cnt    <= '0;
      error  <= 1'b0;
`endif
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            colour <= req_colour[3*win +: 3];
            x0     <= req_x0[9*win +: 9];
            x1     <= req_x1[9*win +: 9];
            y0     <= req_y0[8*win +: 8];
            y1     <= req_y1[8*win +: 8];
            grant  <= NREQ'(1) << win;
            last   <= win;
            go     <= 1'b1;
            busy   <= 1'b1;
            state  <= BUSY;
`ifdef LDA_WATCHDOG_EN
            cnt    <= '0;
`endif
          end
        end
        BUSY: begin
          if (done) begin
            go    <= 1'b0;
            state <= RELEASE;
`ifdef LDA_WATCHDOG_EN
            cnt   <= '0;
`endif
          end
        end
        RELEASE: begin
          if (!done) begin
            ack   <= grant;
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef LDA_WATCHDOG_EN
      // Abort still acks the owner so a hung drawer cannot starve it forever.
      if (state != IDLE) begin
        if (cnt == WD_LAST) begin
          go    <= 1'b0;
          grant <= '0;
          ack   <= grant;
          busy  <= 1'b0;
          error <= 1'b1;
          state <= IDLE;
        end else if (state == RELEASE || !done) begin
          cnt <= cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_line_draw_arbiter.sv
// Scoreboard bench for line_draw_arbiter: expected grants/operands/acks queued at stimulus, checked by a monitor.
module tb_line_draw_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 64;

  logic        clock;
  logic        reset;
  logic [1:0]  req;
  logic [2:0]  op_c  [2];
  logic [8:0]  op_x0 [2];
  logic [8:0]  op_x1 [2];
  logic [7:0]  op_y0 [2];
  logic [7:0]  op_y1 [2];
  logic [5:0]  req_colour;
  logic [17:0] req_x0, req_x1;
  logic [15:0] req_y0, req_y1;
  logic [1:0]  ack, grant;
  logic        busy, done, go;
  logic [2:0]  colour;
  logic [8:0]  x0, x1;
  logic [7:0]  y0, y1;
`ifdef LDA_WATCHDOG_EN
  logic        error;
`endif

  logic        drawer_en, drawer_done, force_done;
  int          gcnt;
  logic [36:0] dut_ops;

  assign req_colour = {op_c[1], op_c[0]};
  assign req_x0     = {op_x0[1], op_x0[0]};
  assign req_x1     = {op_x1[1], op_x1[0]};
  assign req_y0     = {op_y0[1], op_y0[0]};
  assign req_y1     = {op_y1[1], op_y1[0]};
  assign done       = drawer_done | force_done;
  assign dut_ops    = {colour, x0, y0, x1, y1};

  line_draw_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_colour (req_colour),
    .req_x0     (req_x0),
    .req_x1     (req_x1),
    .req_y0     (req_y0),
    .req_y1     (req_y1),
    .ack        (ack),
    .grant      (grant),
    .busy       (busy),
    .done       (done),
    .go         (go),
    .colour     (colour),
    .x0         (x0),
    .x1         (x1),
    .y0         (y0),
    .y1         (y1)
`ifdef LDA_WATCHDOG_EN
    ,
    .error      (error)
`endif
  );

  typedef struct packed {
    logic [1:0]  g;
    logic [36:0] ops;
  } exp_t;

  exp_t       exp_go_q  [$];
  logic [1:0] exp_ack_q [$];
  int         checks;
  int         errors;
  int         rem [2];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [36:0] pack_ops(input logic [2:0] c, input logic [8:0] ax0,
                                           input logic [7:0] ay0, input logic [8:0] ax1,
                                           input logic [7:0] ay1);
    return {c, ax0, ay0, ax1, ay1};
  endfunction

  task automatic set_ops(input int i, input logic [2:0] c, input logic [8:0] ax0,
                         input logic [7:0] ay0, input logic [8:0] ax1, input logic [7:0] ay1);
    op_c[i]  = c;
    op_x0[i] = ax0;
    op_y0[i] = ay0;
    op_x1[i] = ax1;
    op_y1[i] = ay1;
  endtask

  task automatic expect_txn(input logic [1:0] g, input logic [36:0] ops, input logic with_ack);
    exp_go_q.push_back('{g: g, ops: ops});
    if (with_ack) exp_ack_q.push_back(g);
  endtask

  // Requester behaviour: drop req on ack, re-assert next cycle while transactions remain.
  task automatic step();
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (ack[i]) begin
        req[i] = 1'b0;
        rem[i]--;
      end else if (!req[i] && rem[i] > 0) begin
        req[i] = 1'b1;
      end
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(rem[0] == 0 && rem[1] == 0 && req == 2'b00 && !busy && ack == 2'b00) && n < budget);
    check("idle_within_budget", 64'(n < budget), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 2'b00;
    rem   = '{0, 0};
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Drawer model: done rises once go has been seen for 8 samples, falls as soon as go is low.
  initial begin
    drawer_done = 1'b0;
    gcnt        = 0;
    forever begin
      @(posedge clock);
      #1;
      if (go === 1'b1) begin
        if (drawer_en) begin
          gcnt++;
          if (gcnt == 8) drawer_done = 1'b1;
        end
      end else begin
        gcnt        = 0;
        drawer_done = 1'b0;
      end
    end
  end

  // Monitor: compares each go rise and each ack pulse against the scoreboard.
  initial begin
    logic        go_q;
    logic [1:0]  ack_q;
    logic [36:0] cap_ops;
    exp_t        e;
    go_q    = 1'b0;
    ack_q   = 2'b00;
    cap_ops = '0;
    forever begin
      @(posedge clock);
      #1;
      if (go === 1'b1 && go_q == 1'b0) begin
        if (exp_go_q.size() == 0) begin
          check("go_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_go_q.pop_front();
          check("grant", grant, e.g);
          check("operands", dut_ops, e.ops);
        end
        cap_ops = dut_ops;
      end
      if (go === 1'b0 && go_q == 1'b1 && reset) check("operands_stable", dut_ops, cap_ops);
      check("grant_onehot", 64'($countones(grant) > 1), 64'd0);
      if (ack !== 2'b00) begin
        check("ack_single_cycle", ack_q, 2'b00);
        if (exp_ack_q.size() == 0) check("ack_unexpected", ack, 2'b00);
        else                       check("ack", ack, exp_ack_q.pop_front());
      end
      go_q  = go;
      ack_q = ack;
    end
  end

  initial begin
    int n;
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    req        = 2'b00;
    rem        = '{0, 0};
    force_done = 1'b0;
    drawer_en  = 1'b1;
    set_ops(0, 3'd0, 9'd0, 8'd0, 9'd0, 8'd0);
    set_ops(1, 3'd0, 9'd0, 8'd0, 9'd0, 8'd0);

    repeat (3) @(posedge clock);
    #1;
    check("rst_go", go, 1'b0);
    check("rst_grant", grant, 2'b00);
    check("rst_ack", ack, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_operands", dut_ops, 37'd0);
`ifdef LDA_WATCHDOG_EN
    check("rst_error", error, 1'b0);
`endif
    reset = 1'b1;

    // Single transaction from requester 0.
    set_ops(0, 3'd5, 9'd10, 8'd20, 9'd100, 8'd200);
    expect_txn(2'b01, pack_ops(3'd5, 9'd10, 8'd20, 9'd100, 8'd200), 1'b1);
    rem[0] = 1;
    step();
    check("t1_go_before_sample", go, 1'b0);
    step();
    check("t1_go_latency", go, 1'b1);
    check("t1_grant", grant, 2'b01);
    check("t1_x0", x0, 9'd10);
    check("t1_y1", y1, 8'd200);
    n = 0;
    while (ack[0] !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("t1_ack_seen", ack, 2'b01);
    check("t1_busy_at_ack", busy, 1'b0);
    step();
    check("t1_ack_pulse_end", ack, 2'b00);
    check("t1_busy_after", busy, 1'b0);
    run_until_idle(20);

    // Both requesting continuously: strict alternation starting at requester 0.
    do_reset();
    set_ops(0, 3'd1, 9'd1, 8'd2, 9'd3, 8'd4);
    set_ops(1, 3'd2, 9'd300, 8'd100, 9'd400, 8'd250);
    expect_txn(2'b01, pack_ops(3'd1, 9'd1, 8'd2, 9'd3, 8'd4), 1'b1);
    expect_txn(2'b10, pack_ops(3'd2, 9'd300, 8'd100, 9'd400, 8'd250), 1'b1);
    expect_txn(2'b01, pack_ops(3'd1, 9'd1, 8'd2, 9'd3, 8'd4), 1'b1);
    expect_txn(2'b10, pack_ops(3'd2, 9'd300, 8'd100, 9'd400, 8'd250), 1'b1);
    rem = '{2, 2};
    run_until_idle(200);

    // Requester 1 edits its operands while requester 0 owns the drawer.
    set_ops(0, 3'd3, 9'd50, 8'd60, 9'd70, 8'd80);
    set_ops(1, 3'd4, 9'd5, 8'd6, 9'd7, 8'd8);
    expect_txn(2'b01, pack_ops(3'd3, 9'd50, 8'd60, 9'd70, 8'd80), 1'b1);
    expect_txn(2'b10, pack_ops(3'd6, 9'd511, 8'd255, 9'd0, 8'd0), 1'b1);
    rem = '{1, 1};
    repeat (4) step();
    check("t3_r0_owner", grant, 2'b01);
    set_ops(1, 3'd6, 9'd511, 8'd255, 9'd0, 8'd0);
    run_until_idle(200);

    // Reset mid-BUSY: abort without ack, pointer back to requester 0.
    set_ops(0, 3'd7, 9'd11, 8'd22, 9'd33, 8'd44);
    expect_txn(2'b01, pack_ops(3'd7, 9'd11, 8'd22, 9'd33, 8'd44), 1'b0);
    rem[0] = 1;
    repeat (4) step();
    check("t4_busy_before_reset", busy, 1'b1);
    reset = 1'b0;
    req   = 2'b00;
    rem   = '{0, 0};
    @(posedge clock);
    #1;
    check("t4_go_dropped", go, 1'b0);
    check("t4_grant_cleared", grant, 2'b00);
    check("t4_no_ack", ack, 2'b00);
    check("t4_busy_cleared", busy, 1'b0);
    check("t4_operands_cleared", dut_ops, 37'd0);
    @(posedge clock);
    #1;
    check("t4_no_ack_late", ack, 2'b00);
    reset = 1'b1;
    set_ops(0, 3'd2, 9'd12, 8'd13, 9'd14, 8'd15);
    set_ops(1, 3'd5, 9'd200, 8'd150, 9'd250, 8'd100);
    expect_txn(2'b01, pack_ops(3'd2, 9'd12, 8'd13, 9'd14, 8'd15), 1'b1);
    expect_txn(2'b10, pack_ops(3'd5, 9'd200, 8'd150, 9'd250, 8'd100), 1'b1);
    rem = '{1, 1};
    run_until_idle(200);

    // done while idle with no requests must be ignored.
    force_done = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
      check("t5_go_idle", go, 1'b0);
      check("t5_ack_idle", ack, 2'b00);
      check("t5_busy_idle", busy, 1'b0);
    end
    force_done = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("t5_still_idle", busy, 1'b0);

`ifdef LDA_WATCHDOG_EN
    // Hung drawer: abort after TIMEOUT cycles of go, still ack, sticky error.
    begin
      int hi;
      drawer_en = 1'b0;
      set_ops(0, 3'd1, 9'd9, 8'd9, 9'd9, 8'd9);
      expect_txn(2'b01, pack_ops(3'd1, 9'd9, 8'd9, 9'd9, 8'd9), 1'b1);
      rem[0] = 1;
      hi = 0;
      n  = 0;
      while (n < 300) begin
        step();
        n++;
        if (go) hi++;
        if (ack[0]) break;
      end
      check("wd_go_cycles", 64'(hi), 64'(TIMEOUT));
      check("wd_error_set", error, 1'b1);
      drawer_en = 1'b1;
      run_until_idle(20);
      set_ops(1, 3'd3, 9'd1, 8'd1, 9'd2, 8'd2);
      expect_txn(2'b10, pack_ops(3'd3, 9'd1, 8'd1, 9'd2, 8'd2), 1'b1);
      rem[1] = 1;
      run_until_idle(100);
      check("wd_error_sticky", error, 1'b1);
    end
`endif

    repeat (2) @(posedge clock);
    #1;
    check("go_queue_drained", 64'(exp_go_q.size()), 64'd0);
    check("ack_queue_drained", 64'(exp_ack_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
